// File: rtl/fft_frame_controller.sv
// Frame sequencer between the sample stream and FFT_Processor: buffers 16 samples, strobes new_t,
// captures the bins on done, and tracks timeouts/drops. Define FFT_CTRL_OVERLAP_EN for a shadow buffer.
module fft_frame_controller #(
    parameter int SAMPLE_W       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic [SAMPLE_W-1:0]    sample_in,
    output logic                   fft_new_t,
    output logic [16*SAMPLE_W-1:0] fft_t_flat,
    input  logic                   fft_done,
    input  logic [16*SAMPLE_W-1:0] fft_f_flat,
    output logic [16*SAMPLE_W-1:0] spectrum_out,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic [7:0]             drop_count,
    output logic                   timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [3:0]               wr_idx_q;
    logic [TMO_W-1:0]         tmo_cnt_q;
    logic                     fft_new_t_q;
    logic                     frame_valid_q;
    logic                     busy_q;
    logic                     overrun_q;
    logic [7:0]               drop_count_q;
    logic                     timeout_err_q;
    logic [16*SAMPLE_W-1:0]   spectrum_q;
    logic                     drop_s;

`ifdef FFT_CTRL_OVERLAP_EN
    logic [SAMPLE_W-1:0]      buf_q [2][16];
    logic                     act_sel_q;
    logic [3:0]               sh_idx_q;
    logic                     sh_full_q;
    logic                     sh_accept_s;
    logic [3:0]               sh_idx_d;
    logic                     sh_full_d;

    // Shadow-buffer acceptance while the FFT owns the active buffer; a full shadow drops the sample.
    always_comb begin
        drop_s      = 1'b0;
        sh_accept_s = 1'b0;
        sh_idx_d    = sh_idx_q;
        sh_full_d   = sh_full_q;
        if (busy_q && sample_valid) begin
            if (sh_full_q) begin
                drop_s = 1'b1;
            end else begin
                sh_accept_s = 1'b1;
                sh_idx_d    = sh_idx_q + 4'd1;
                sh_full_d   = (sh_idx_q == 4'd15);
            end
        end else begin
            drop_s = 1'b0;
        end
    end
`else
    logic [SAMPLE_W-1:0]      buf_q [16];

    // Without a shadow buffer every sample arriving while the FFT is busy is lost.
    always_comb begin
        drop_s = 1'b0;
        if (busy_q && sample_valid) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end
`endif

    // Frame FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FILL;
            wr_idx_q      <= 4'd0;
            tmo_cnt_q     <= '0;
            fft_new_t_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            drop_count_q  <= 8'd0;
            timeout_err_q <= 1'b0;
            spectrum_q    <= '0;
`ifdef FFT_CTRL_OVERLAP_EN
            act_sel_q     <= 1'b0;
            sh_idx_q      <= 4'd0;
            sh_full_q     <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[b][i] <= '0;
                end
            end
`else
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
`endif
        end else begin
            fft_new_t_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            if (drop_s) begin
                overrun_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
`ifdef FFT_CTRL_OVERLAP_EN
            if (sh_accept_s) begin
                buf_q[~act_sel_q][sh_idx_q] <= sample_in;
            end
            sh_idx_q  <= sh_idx_d;
            sh_full_q <= sh_full_d;
`endif
            case (state_q)
                S_FILL: begin
                    if (sample_valid) begin
`ifdef FFT_CTRL_OVERLAP_EN
                        buf_q[act_sel_q][wr_idx_q] <= sample_in;
`else
                        buf_q[wr_idx_q] <= sample_in;
`endif
                        wr_idx_q <= wr_idx_q + 4'd1;
                        if (wr_idx_q == 4'd15) begin
                            state_q     <= S_START;
                            fft_new_t_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state_q   <= S_WAIT;
                    tmo_cnt_q <= '0;
                end
                S_WAIT: begin
                    // Done beats a coincident timeout; both end the frame the same way apart from capture.
                    if (fft_done || (tmo_cnt_q == TMO_LAST)) begin
                        if (fft_done) begin
                            spectrum_q    <= fft_f_flat;
                            frame_valid_q <= 1'b1;
                        end else begin
                            timeout_err_q <= 1'b1;
                        end
`ifdef FFT_CTRL_OVERLAP_EN
                        act_sel_q <= ~act_sel_q;
                        wr_idx_q  <= sh_idx_d;
                        sh_idx_q  <= 4'd0;
                        sh_full_q <= 1'b0;
                        if (sh_full_d) begin
                            state_q     <= S_START;
                            fft_new_t_q <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= S_FILL;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= S_FILL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_tflat
`ifdef FFT_CTRL_OVERLAP_EN
        assign fft_t_flat[SAMPLE_W*g +: SAMPLE_W] = buf_q[act_sel_q][g];
`else
        assign fft_t_flat[SAMPLE_W*g +: SAMPLE_W] = buf_q[g];
`endif
    end

    assign fft_new_t    = fft_new_t_q;
    assign frame_valid  = frame_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign drop_count   = drop_count_q;
    assign timeout_err  = timeout_err_q;
    assign spectrum_out = spectrum_q;

endmodule

// File: tb/tb_fft_frame_controller.sv
// Self-checking bench for fft_frame_controller (default build): frame-level model plus directed checks.
module tb_fft_frame_controller;

    localparam int SW  = 16;
    localparam int TMO = 64;

    logic            clk;
    logic            reset;
    logic            sample_valid;
    logic [SW-1:0]   sample_in;
    logic            fft_new_t;
    logic [16*SW-1:0] fft_t_flat;
    logic            fft_done;
    logic [16*SW-1:0] fft_f_flat;
    logic [16*SW-1:0] spectrum_out;
    logic            frame_valid;
    logic            busy;
    logic            overrun;
    logic [7:0]      drop_count;
    logic            timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    fft_frame_controller #(.SAMPLE_W(SW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .fft_new_t(fft_new_t), .fft_t_flat(fft_t_flat), .fft_done(fft_done),
        .fft_f_flat(fft_f_flat), .spectrum_out(spectrum_out), .frame_valid(frame_valid),
        .busy(busy), .overrun(overrun), .drop_count(drop_count), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] word(input logic [16*SW-1:0] v, input int i);
        return v[SW*i +: SW];
    endfunction

    // Frame-level model: a collecting frame, an FFT-in-flight flag and a count of waited cycles.
    bit              m_running, m_launch;
    int              m_fill, m_wait, m_drops;
    bit              m_new_t, m_fv, m_over, m_tmo;
    logic [16*SW-1:0] m_spec, m_t;

    always @(posedge clk) begin
        if (reset) begin
            m_running = 0; m_launch = 0; m_fill = 0; m_wait = 0; m_drops = 0;
            m_new_t = 0; m_fv = 0; m_over = 0; m_tmo = 0; m_spec = '0; m_t = '0;
        end else begin
            m_new_t = 0;
            m_fv    = 0;
            if (!m_running) begin
                if (sample_valid) begin
                    m_t[SW*m_fill +: SW] = sample_in;
                    m_fill++;
                    if (m_fill == 16) begin
                        m_fill = 0; m_running = 1; m_launch = 1; m_new_t = 1; m_wait = 0;
                    end
                end
            end else begin
                if (sample_valid) begin
                    m_over = 1;
                    if (m_drops < 255) m_drops++;
                end
                if (m_launch) begin
                    m_launch = 0;
                end else if (fft_done) begin
                    m_spec = fft_f_flat; m_fv = 1; m_running = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_tmo = 1; m_running = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_new_t", 256'(fft_new_t), 256'(m_new_t));
            check("m_t_flat", fft_t_flat, m_t);
            check("m_spectrum", spectrum_out, m_spec);
            check("m_frame_valid", 256'(frame_valid), 256'(m_fv));
            check("m_busy", 256'(busy), 256'(m_running));
            check("m_overrun", 256'(overrun), 256'(m_over));
            check("m_drop_count", 256'(drop_count), 256'(m_drops));
            check("m_timeout_err", 256'(timeout_err), 256'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill16(input int base, input int step);
        for (int i = 0; i < 16; i++) begin
            sample_valid = 1'b1;
            sample_in    = SW'(base + step * i);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    logic [16*SW-1:0] f_v;
    int               cnt;

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0; fft_done = 1'b0; fft_f_flat = '0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        check("rst_new_t", 256'(fft_new_t), 256'd0);
        check("rst_t_flat", fft_t_flat, 256'd0);
        check("rst_spectrum", spectrum_out, 256'd0);
        check("rst_flags", {253'd0, overrun, timeout_err, busy}, 256'd0);
        check("rst_drop_count", 256'(drop_count), 256'd0);
        reset = 1'b0;
        tick();

        // Basic frame: 10,0,10,0,...
        for (int i = 0; i < 16; i++) begin
            sample_valid = 1'b1;
            sample_in    = (i % 2 == 0) ? 16'd10 : 16'd0;
            tick();
        end
        sample_valid = 1'b0;
        check("basic_new_t_hi", 256'(fft_new_t), 256'd1);
        for (int i = 0; i < 16; i++)
            check("basic_t_word", 256'(word(fft_t_flat, i)), (i % 2 == 0) ? 256'd10 : 256'd0);
        tick();
        check("basic_new_t_lo", 256'(fft_new_t), 256'd0);
        check("basic_busy", 256'(busy), 256'd1);
        repeat (11) tick();
        f_v = '0; f_v[15:0] = 16'd80; f_v[8*SW +: SW] = 16'd80;
        fft_done = 1'b1; fft_f_flat = f_v;
        tick();
        fft_done = 1'b0; fft_f_flat = '0;
        check("basic_fv_hi", 256'(frame_valid), 256'd1);
        for (int i = 0; i < 16; i++)
            check("basic_spec_word", 256'(word(spectrum_out, i)), (i == 0 || i == 8) ? 256'd80 : 256'd0);
        tick();
        check("basic_fv_lo", 256'(frame_valid), 256'd0);

        // Timeout: no done ever arrives.
        fill16(1, 3);
        cnt = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            cnt++;
            tick();
        end
        check("tmo_busy_cycles", 256'(cnt), 256'd65);
        check("tmo_err", 256'(timeout_err), 256'd1);
        check("tmo_spec_kept0", 256'(word(spectrum_out, 0)), 256'd80);
        check("tmo_spec_kept8", 256'(word(spectrum_out, 8)), 256'd80);

        // Done during FILL is ignored.
        fft_done = 1'b1; fft_f_flat = {16{16'hDEAD}};
        tick();
        fft_done = 1'b0;
        check("fill_done_ignored", 256'(frame_valid), 256'd0);

        // Overrun: two samples in WAIT, one coincident with done.
        fill16(100, 1);
        tick();
        sample_valid = 1'b1; sample_in = 16'd900; tick();
        sample_in = 16'd901; tick();
        sample_valid = 1'b0; tick();
        f_v = '0; f_v[3*SW +: SW] = 16'h1234;
        sample_valid = 1'b1; sample_in = 16'd902; fft_done = 1'b1; fft_f_flat = f_v;
        tick();
        sample_valid = 1'b0; fft_done = 1'b0;
        check("ovr_fv", 256'(frame_valid), 256'd1);
        check("ovr_drop_count", 256'(drop_count), 256'd3);
        check("ovr_flag", 256'(overrun), 256'd1);
        check("ovr_spec_w3", 256'(word(spectrum_out, 3)), 256'h1234);
        fill16(200, 1);
        check("ovr_next_t0", 256'(word(fft_t_flat, 0)), 256'd200);
        check("ovr_next_t15", 256'(word(fft_t_flat, 15)), 256'd215);
        check("ovr_next_new_t", 256'(fft_new_t), 256'd1);
        tick(); tick();
        fft_done = 1'b1; fft_f_flat = {16{16'h0055}};
        tick();
        fft_done = 1'b0;
        check("ovr_next_fv", 256'(frame_valid), 256'd1);
        tick();

        // Reset while waiting, done arrives afterwards.
        fill16(50, 2);
        tick(); tick(); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        check("rw_new_t", 256'(fft_new_t), 256'd0);
        check("rw_t_flat", fft_t_flat, 256'd0);
        check("rw_spectrum", spectrum_out, 256'd0);
        check("rw_flags", {253'd0, overrun, timeout_err, busy}, 256'd0);
        check("rw_drop_count", 256'(drop_count), 256'd0);
        tick();
        fft_done = 1'b1; fft_f_flat = {16{16'h7777}};
        tick();
        fft_done = 1'b0;
        check("rw_no_fv", 256'(frame_valid), 256'd0);
        sample_valid = 1'b1; sample_in = 16'd7; tick();
        sample_valid = 1'b0;
        check("rw_t0_restart", 256'(word(fft_t_flat, 0)), 256'd7);
        tick(); tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
